// File: rtl/aria_pkg.sv
// Shared encodings for the ARIA key-schedule controller: key lengths, FSM states,
// round-constant selects and round-key counts per key length.
package aria_pkg;

  typedef enum logic [1:0] {
    KLEN_128 = 2'd0,
    KLEN_192 = 2'd1,
    KLEN_256 = 2'd2,
    KLEN_BAD = 2'd3
  } key_len_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_REQ,
    ST_INIT_WAIT,
    ST_SHIFT,
    ST_GEN,
    ST_DONE
  } ks_state_e;

  typedef enum logic [1:0] {
    CK_SEL_1 = 2'd0,
    CK_SEL_2 = 2'd1,
    CK_SEL_3 = 2'd2
  } ck_sel_e;

  localparam int unsigned NR_128 = 13;
  localparam int unsigned NR_192 = 15;
  localparam int unsigned NR_256 = 17;

  localparam logic [1:0] LAST_STEP = 2'd2;

  function automatic int unsigned rk_count(input logic [1:0] len);
    case (len)
      KLEN_128: return NR_128;
      KLEN_192: return NR_192;
      default:  return NR_256;
    endcase
  endfunction

  // Initial-key constant rotates with key length: (len + step) mod 3.
  function automatic ck_sel_e ck_select(input logic [1:0] len, input logic [1:0] step);
    logic [2:0] sum;
    sum = {1'b0, len} + {1'b0, step};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return ck_sel_e'(sum[1:0]);
  endfunction

endpackage

// File: rtl/aria_key_sched_ctrl.sv
// ARIA key-schedule sequencer: three round-function passes build W1..W3, then
// round keys are handed out one per rk_ack. Define ARIA_KS_DEC_EN for descending order.
module aria_key_sched_ctrl
  import aria_pkg::*;
#(
  parameter int NR_MAX = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         key_start,
  input  logic [1:0]                   key_len,
  input  logic                         key_dec,
  output logic                         key_busy,
  output logic                         key_done,
  output logic                         key_err,
  output logic                         f_req,
  input  logic                         f_gnt,
  input  logic                         f_vld,
  output logic                         f_odd,
  output logic [1:0]                   ck_sel,
  output logic                         key_ready,
  output logic                         w_ready,
  output logic                         rk_valid,
  input  logic                         rk_ack,
  output logic [$clog2(NR_MAX+1)-1:0]  rk_idx
);

  localparam int IDX_W = $clog2(NR_MAX + 1);

  ks_state_e         state_q, state_d;
  logic [1:0]        step_q, step_d;
  logic [1:0]        len_q, len_d;
  logic              err_q, err_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic              start_dec;
  logic              run_dec;
  logic [IDX_W-1:0]  start_first;
  logic [IDX_W-1:0]  run_last;

`ifdef ARIA_KS_DEC_EN
  logic dec_q, dec_d;

  always_comb begin
    dec_d = dec_q;
    if (state_q == ST_IDLE && key_start && key_len != KLEN_BAD) dec_d = key_dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dec_q <= 1'b0;
    else        dec_q <= dec_d;
  end

  assign start_dec = key_dec;
  assign run_dec   = dec_q;
`else
  logic unused_key_dec;
  assign unused_key_dec = key_dec;
  assign start_dec      = 1'b0;
  assign run_dec        = 1'b0;
`endif

  // Index range is fixed at start; the final ack never moves the index past it.
  assign start_first = start_dec ? IDX_W'(rk_count(key_len) - 1) : '0;
  assign run_last    = run_dec   ? '0 : IDX_W'(rk_count(len_q) - 1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    step_d    = step_q;
    len_d     = len_q;
    idx_d     = idx_q;
    err_d     = 1'b0;
    key_busy  = 1'b1;
    key_ready = 1'b1;
    key_done  = 1'b0;
    f_req     = 1'b0;
    f_odd     = 1'b0;
    ck_sel    = 2'd0;
    w_ready   = 1'b1;
    rk_valid  = 1'b0;

    if (state_q inside {ST_INIT_REQ, ST_INIT_WAIT, ST_SHIFT}) begin
      f_odd  = (step_q != 2'd1);
      ck_sel = ck_select(len_q, step_q);
    end

    unique case (state_q)
      ST_IDLE: begin
        key_busy  = 1'b0;
        key_ready = 1'b0;
        if (key_start) begin
          if (key_len == KLEN_BAD) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_INIT_REQ;
            step_d  = 2'd0;
            len_d   = key_len;
            idx_d   = start_first;
          end
        end
      end
      ST_INIT_REQ: begin
        f_req = 1'b1;
        if (f_gnt) state_d = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        if (f_vld) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_ready = 1'b0;
        if (step_q == LAST_STEP) begin
          state_d = ST_GEN;
        end else begin
          step_d  = step_q + 2'd1;
          state_d = ST_INIT_REQ;
        end
      end
      ST_GEN: begin
        rk_valid = 1'b1;
        if (rk_ack) begin
          if (idx_q == run_last) state_d = ST_DONE;
          else if (run_dec)      idx_d   = idx_q - IDX_W'(1);
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        key_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= 2'd0;
      len_q   <= 2'd0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  assign key_err = err_q;
  assign rk_idx  = idx_q;

endmodule

// File: doc/aria_key_sched_ctrl.md
AES_KEY... no -- ARIA_KEY_SCHED_CTRL -- requirements
Module: aria_key_sched_ctrl

Interface
REQ-001 SHALL have parameter NR_MAX, default 16, meaning maximum round count (sizes rk_idx).
REQ-002 SHALL have ports: clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have key_start  in  1  start pulse; key_len  in  2  0=128b, 1=192b, 2=256b, 3=illegal.
REQ-004 SHALL have key_dec  in  1  decryption key order (sampled at start, used only per REQ-030).
REQ-005 SHALL have key_busy  out  1  schedule in progress; key_done  out  1  one-cycle completion pulse; key_err  out  1  one-cycle illegal-length pulse.
REQ-006 SHALL have f_req  out  1  round-function request; f_gnt  in  1  grant; f_vld  in  1  result valid pulse.
REQ-007 SHALL have f_odd  out  1  1=Fo, 0=Fe; ck_sel  out  2  constant select 0=CK1, 1=CK2, 2=CK3.
REQ-008 SHALL have key_ready  out  1 and w_ready  out  1, driving the key-extension register shift (shift occurs when key_ready=1 and w_ready=0).
REQ-009 SHALL have rk_valid  out  1; rk_ack  in  1; rk_idx  out  $clog2(NR_MAX+1)  round-key index.
REQ-010 Clock is clk, single domain; reset is rst_n, asynchronous assert, active-low.

Function
REQ-011 FSM states SHALL be IDLE, INIT_REQ, INIT_WAIT, SHIFT, GEN, DONE.
REQ-012 IDLE: key_start with key_len<3 -> INIT_REQ, step=0, key_busy=1, key_ready=1, length latched.
REQ-013 IDLE: key_start with key_len=3 -> key_err=1 next cycle, stay IDLE.
REQ-014 key_start outside IDLE SHALL be ignored (no restart, no error).
REQ-015 INIT_REQ: f_req=1 held until f_gnt=1; same-cycle grant -> INIT_WAIT next cycle.
REQ-016 INIT_WAIT: f_req=0; f_vld=1 -> SHIFT; f_vld outside INIT_WAIT SHALL be ignored.
REQ-017 f_odd SHALL be 1 for step 0 and 2, 0 for step 1, stable from INIT_REQ through SHIFT.
REQ-018 ck_sel SHALL equal (latched key_len + step) mod 3, stable from INIT_REQ through SHIFT.
REQ-019 SHIFT: exactly one cycle with w_ready=0; w_ready=1 in every other state.
REQ-020 SHIFT: step<2 -> step+1, INIT_REQ; step=2 -> GEN.
REQ-021 Round-key count N SHALL be 13/15/17 for key_len 0/1/2.
REQ-022 GEN: rk_valid=1; rk_idx starts 0, increments on each rk_ack; rk_ack when rk_valid=0 ignored.
REQ-023 GEN: rk_ack with rk_idx=N-1 -> DONE; rk_valid low from next cycle.
REQ-024 DONE: key_done=1 for one cycle, key_busy=0 and key_ready=0 next cycle, -> IDLE.
REQ-025 rk_idx SHALL hold its final value in IDLE until next start; never wraps.
REQ-026 Latency with f_gnt tied 1 and f_vld 1 cycle after grant: key_start to first rk_valid = 10 cycles.

Reset
REQ-027 rst_n low SHALL force: state IDLE, key_busy 0, key_done 0, key_err 0, f_req 0, f_odd 0, ck_sel 0, key_ready 0, w_ready 1, rk_valid 0, rk_idx 0, step 0.
REQ-028 Reset mid-operation SHALL abandon the schedule; no key_done issued.
REQ-029 First cycle after reset release SHALL accept key_start.

Configuration
REQ-030 Macro ARIA_KS_DEC_EN defined: key_dec=1 at start makes GEN begin rk_idx=N-1, decrement on rk_ack, finish at 0.
REQ-031 Macro undefined: key_dec port present but ignored; rk_idx always ascends.

Structure
REQ-032 Shared package aria_pkg SHALL hold key_len encodings, FSM state enum, CK select encoding, and N-per-length constants.
REQ-033 No sub-module; single flat FSM plus step and index counters.

Verification
REQ-034 key_len=0, f_gnt=1, f_vld 1 cycle after grant -> ck_sel 0,1,2; f_odd 1,0,1; three w_ready=0 pulses; rk_idx 0..12; key_done once.
REQ-035 key_len=2 -> ck_sel 2,0,1; rk_idx 0..16; key_done after 17th rk_ack.
REQ-036 key_len=3 -> key_err one cycle, key_busy stays 0, f_req never asserted.
REQ-037 f_gnt held 0 for 5 cycles -> f_req held 1, ck_sel/f_odd stable, no shift; second key_start during wait ignored.
REQ-038 rst_n low while GEN at rk_idx=5 -> all outputs at reset values, no key_done; new key_start runs full schedule.
REQ-039 ARIA_KS_DEC_EN, key_len=1, key_dec=1 -> rk_idx 14 down to 0, key_done after 15th rk_ack.
